// File: rtl/bank_xpose_ctrl.sv
// bank_xpose_ctrl: M x M tile transposer in front of a banked SRAM.
// Rows are written with a diagonal skew so that element (r,c) sits at
// r*M + ((r+c) mod M). A full row write and a full column read therefore
// each touch M distinct banks when NB == M. The tile is written row by row,
// then read back column by column and streamed out.
module bank_xpose_ctrl #(
  parameter int M      = 8,
  parameter int NB     = 8,
  parameter int ADDR_W = 12,
  parameter int Data_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_v,
  output logic                  in_ready,
  input  logic [M*Data_W-1:0]   in_row,
  output logic                  out_v,
  input  logic                  out_ready,
  output logic [M*Data_W-1:0]   out_col,
  output logic [M-1:0]          req_v,
  output logic [M-1:0]          req_we,
  output logic [M*ADDR_W-1:0]   Req_addr,
  output logic [M*Data_W-1:0]   Req_wData,
  input  logic [M-1:0]          req_ready,
  input  logic [M-1:0]          rsp_v,
  input  logic [M*Data_W-1:0]   Rsp_rData,
  output logic                  tile_done
);

  // Index width for rows/columns; M must be a power of two and at least 2.
  localparam int LM = $clog2(M);
  localparam logic [LM-1:0] LAST = LM'(M - 1);

  localparam logic [1:0] WR  = 2'd0;
  localparam logic [1:0] RD  = 2'd1;
  localparam logic [1:0] OUT = 2'd2;

  // Elaboration-time sanity check on the geometry.
  if ((M < 2) || ((M & (M - 1)) != 0) || (NB < 1) || ((NB & (NB - 1)) != 0) ||
      (M * M > (1 << ADDR_W))) begin : g_bad_cfg
    $error("bank_xpose_ctrl: M and NB must be powers of two, M >= 2, M*M <= 2**ADDR_W");
  end

  logic [1:0]           state_reg;
  logic [LM-1:0]        row_cnt_reg;   // next row index to accept
  logic [LM-1:0]        cur_row_reg;   // row index of the latched row
  logic [LM-1:0]        col_reg;       // column currently being read/emitted
  logic [M-1:0]         pend_reg;      // per-stream request still waiting for a grant
  logic [M-1:0]         outs_reg;      // per-stream read granted, response not yet seen
  logic [M-1:0]         got_reg;       // per-slot column buffer filled
  logic [M*Data_W-1:0]  row_buf_reg;
  logic [M*Data_W-1:0]  col_buf_reg;

  logic [M-1:0] grant;
  logic [M-1:0] pend_left;
  logic [M-1:0] rsp_ok;
  logic         accept;
  logic         out_fire;
  logic         last_col;

  assign in_ready  = (state_reg == WR) && (pend_reg == '0);
  assign accept    = in_v && in_ready;
  assign grant     = req_v & req_ready;
  assign pend_left = pend_reg & ~req_ready;
  // Responses only count for streams with a read in flight.
  assign rsp_ok    = rsp_v & outs_reg & {M{state_reg == RD}};
  assign out_v     = (state_reg == OUT);
  assign out_col   = col_buf_reg;
  assign out_fire  = out_v && out_ready;
  assign last_col  = (col_reg == LAST);
  assign tile_done = out_fire && last_col;

  assign req_v  = (state_reg == OUT) ? '0 : pend_reg;
  assign req_we = (state_reg == WR)  ? pend_reg : '0;

  // Per-stream address and write data. In WR stream c writes element c of the
  // latched row; in RD stream r reads row r of the current column. Outputs are
  // zero whenever the stream is idle so the bus is quiet in reset and OUT.
  genvar gi;
  for (gi = 0; gi < M; gi++) begin : g_stream
    logic [LM-1:0] row_idx;
    logic [LM-1:0] col_idx;
    logic [LM-1:0] diag;
    assign row_idx = (state_reg == WR) ? cur_row_reg : LM'(gi);
    assign col_idx = (state_reg == WR) ? LM'(gi) : col_reg;
    // Wraps naturally: (row + col) mod M.
    assign diag    = row_idx + col_idx;
    assign Req_addr[gi*ADDR_W +: ADDR_W]  = req_v[gi] ? ADDR_W'({row_idx, diag}) : '0;
    assign Req_wData[gi*Data_W +: Data_W] = req_we[gi] ? row_buf_reg[gi*Data_W +: Data_W] : '0;
  end

  // Control FSM: row writes, column reads, column hand-off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= WR;
      row_cnt_reg <= '0;
      cur_row_reg <= '0;
      col_reg     <= '0;
      pend_reg    <= '0;
      outs_reg    <= '0;
      got_reg     <= '0;
      row_buf_reg <= '0;
    end else begin
      case (state_reg)
        WR: begin
          if (accept) begin
            row_buf_reg <= in_row;
            cur_row_reg <= row_cnt_reg;
            row_cnt_reg <= row_cnt_reg + LM'(1);
            pend_reg    <= '1;
          end else if (pend_reg != '0) begin
            if ((pend_left == '0) && (cur_row_reg == LAST)) begin
              // Last row fully written: start reading column 0.
              state_reg <= RD;
              col_reg   <= '0;
              pend_reg  <= '1;
            end else begin
              pend_reg <= pend_left;
            end
          end
        end
        RD: begin
          pend_reg <= pend_left;
          outs_reg <= (outs_reg & ~rsp_ok) | grant;
          got_reg  <= got_reg | rsp_ok;
          if (got_reg == '1) begin
            state_reg <= OUT;
          end
        end
        OUT: begin
          if (out_fire) begin
            got_reg <= '0;
            if (last_col) begin
              state_reg   <= WR;
              row_cnt_reg <= '0;
              col_reg     <= '0;
            end else begin
              state_reg <= RD;
              col_reg   <= col_reg + LM'(1);
              pend_reg  <= '1;
            end
          end
        end
        default: state_reg <= WR;
      endcase
    end
  end

  // Column buffer: capture each accepted read response into its row slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_buf_reg <= '0;
    end else begin
      for (int i = 0; i < M; i++) begin
        if (rsp_ok[i]) begin
          col_buf_reg[i*Data_W +: Data_W] <= Rsp_rData[i*Data_W +: Data_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_bank_xpose_ctrl.sv
// tb_bank_xpose_ctrl: self-checking bench for bank_xpose_ctrl with M=NB=4.
// A behavioural banked SRAM answers requests; expected columns are queued
// when a tile's rows are driven and compared when the DUT hands them off.
module tb_bank_xpose_ctrl;

  localparam int M  = 4;
  localparam int DW = 16;
  localparam int AW = 12;

  logic               clk;
  logic               rst_n;
  logic               in_v;
  logic               in_ready;
  logic [M*DW-1:0]    in_row;
  logic               out_v;
  logic               out_ready;
  logic [M*DW-1:0]    out_col;
  logic [M-1:0]       req_v;
  logic [M-1:0]       req_we;
  logic [M*AW-1:0]    Req_addr;
  logic [M*DW-1:0]    Req_wData;
  logic [M-1:0]       req_ready;
  logic [M-1:0]       rsp_v;
  logic [M*DW-1:0]    Rsp_rData;
  logic               tile_done;

  bank_xpose_ctrl #(.M(M), .NB(4), .ADDR_W(AW), .Data_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_v(in_v), .in_ready(in_ready), .in_row(in_row),
    .out_v(out_v), .out_ready(out_ready), .out_col(out_col),
    .req_v(req_v), .req_we(req_we), .Req_addr(Req_addr), .Req_wData(Req_wData),
    .req_ready(req_ready), .rsp_v(rsp_v), .Rsp_rData(Rsp_rData),
    .tile_done(tile_done)
  );

  typedef struct {
    logic [63:0] col;
    bit          last;
    bit          first;
  } exp_t;

  typedef struct {
    logic [15:0] base;
    bit          throttle;
    int          stall_col;
    int          stall_len;
    int          gap;
    int          lat;
    logic [63:0] col0;
  } vec_t;

  exp_t        exp_q[$];
  vec_t        vecs[3];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          ncols = 0;
  int          done_cyc = -1;
  int          prev_done_cyc = -1;
  int          first_acc_cyc = 0;
  int          last_acc_cyc = 0;
  logic [63:0] col0_seen = '0;
  bit          throttle = 1'b0;
  bit          spur = 1'b0;
  logic [15:0] mem [0:4095];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] col_word(input logic [15:0] base, input int c);
    logic [63:0] w;
    for (int r = 0; r < M; r++) w[r*DW +: DW] = 16'(base + 16 * r + c);
    return w;
  endfunction

  // Banked SRAM model: grant at the negedge view, write immediately,
  // return read data in the following cycle.
  initial begin
    logic [M-1:0]    nv;
    logic [M*DW-1:0] nd;
    logic [AW-1:0]   a;
    logic [3:0]      used;
    bit              dup;
    req_ready = '1;
    rsp_v     = '0;
    Rsp_rData = '0;
    forever begin
      @(negedge clk);
      nv = '0;
      nd = '0;
      if (rst_n) begin
        for (int m = 0; m < M; m++) begin
          if (req_v[m] && req_ready[m]) begin
            a = Req_addr[m*AW +: AW];
            if (req_we[m]) mem[a] = Req_wData[m*DW +: DW];
            else begin
              nv[m] = 1'b1;
              nd[m*DW +: DW] = mem[a];
            end
          end
        end
        if (!throttle && (req_v != '0)) begin
          used = '0;
          dup  = 1'b0;
          for (int m = 0; m < M; m++) begin
            if (req_v[m]) begin
              if (used[Req_addr[m*AW +: 2]]) dup = 1'b1;
              used[Req_addr[m*AW +: 2]] = 1'b1;
            end
          end
          chk("bank_conflict", 64'(dup), 64'(0));
        end
      end
      if (spur) begin
        nv = '1;
        nd = {4{16'hDEAD}};
      end
      @(posedge clk);
      #1;
      rsp_v     = nv;
      Rsp_rData = nd;
      req_ready = throttle ? 4'(4'b0001 << (cyc % 4)) : 4'b1111;
    end
  end

  // Scoreboard: compare every handed-off column against the queued model.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_v && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_col", out_col, 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("out_col", out_col, e.col);
          chk("tile_done", 64'(tile_done), 64'(e.last));
          $display("col %0d handed off: %h tile_done=%0d", ncols, out_col, tile_done);
          if (e.first) col0_seen = out_col;
        end
        ncols++;
        if (tile_done) begin
          prev_done_cyc = done_cyc;
          done_cyc      = cyc;
        end
      end else if (tile_done) begin
        chk("tile_done_spurious", 64'(tile_done), 64'(0));
      end
    end
  end

  task automatic send_rows(input logic [15:0] base, input int exp_gap);
    int  acc[M];
    bit  ok;
    exp_t e;
    for (int c = 0; c < M; c++) begin
      e.col   = col_word(base, c);
      e.last  = (c == M - 1);
      e.first = (c == 0);
      exp_q.push_back(e);
    end
    for (int r = 0; r < M; r++) begin
      for (int c = 0; c < M; c++) in_row[c*DW +: DW] = 16'(base + 16 * r + c);
      in_v = 1'b1;
      ok   = 1'b0;
      for (int k = 0; k < 400; k++) begin
        @(negedge clk);
        if (in_ready) begin
          ok = 1'b1;
          break;
        end
      end
      chk("row_accept", 64'(ok), 64'(1));
      acc[r] = cyc;
      last_acc_cyc = cyc;
      if (r == 0) first_acc_cyc = cyc;
      $display("row %0d of tile %h accepted at cycle %0d", r, base, cyc);
      @(posedge clk);
      #1;
      in_v = 1'b0;
    end
    if (exp_gap > 0) begin
      for (int r = 1; r < M; r++) chk("row_gap", 64'(acc[r] - acc[r-1]), 64'(exp_gap));
    end
  endtask

  task automatic wait_cols(input int n);
    for (int k = 0; k < 500; k++) begin
      if (ncols >= n) break;
      @(negedge clk);
      #1;
    end
    chk("col_count", 64'(ncols >= n), 64'(1));
  endtask

  task automatic drain(input logic [15:0] base, input int stall_col, input int stall_len, input int exp_lat);
    int n0;
    bit ok;
    n0 = ncols;
    if (stall_len == 0) begin
      out_ready = 1'b1;
      if (exp_lat > 0) begin
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
          @(negedge clk);
          if (out_v) begin
            ok = 1'b1;
            break;
          end
        end
        chk("out_v_wait", 64'(ok), 64'(1));
        chk("col_latency", 64'(cyc - last_acc_cyc), 64'(exp_lat));
      end
    end else begin
      out_ready = 1'b0;
      for (int c = 0; c < M; c++) begin
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
          @(negedge clk);
          if (out_v) begin
            ok = 1'b1;
            break;
          end
        end
        chk("out_v_wait", 64'(ok), 64'(1));
        if (c == stall_col) begin
          for (int s = 0; s < stall_len; s++) begin
            if (s > 0) @(negedge clk);
            chk("stall_out_v", 64'(out_v), 64'(1));
            chk("stall_out_col", out_col, col_word(base, c));
            chk("stall_req_v", 64'(req_v), 64'(0));
          end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
      end
      out_ready = 1'b1;
    end
    wait_cols(n0 + M);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req_v"},     64'(req_v),     64'(0));
    chk({tag, "_req_we"},    64'(req_we),    64'(0));
    chk({tag, "_req_addr"},  64'(Req_addr),  64'(0));
    chk({tag, "_req_wdata"}, 64'(Req_wData), 64'(0));
    chk({tag, "_out_v"},     64'(out_v),     64'(0));
    chk({tag, "_out_col"},   out_col,        64'(0));
    chk({tag, "_tile_done"}, 64'(tile_done), 64'(0));
    chk({tag, "_in_ready"},  64'(in_ready),  64'(1));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'h000, 1'b0, -1, 0, 2,  5, 64'h0030_0020_0010_0000};
    vecs[1] = '{16'h000, 1'b0,  1, 5, 2, -1, 64'h0030_0020_0010_0000};
    vecs[2] = '{16'h000, 1'b1, -1, 0, 5, -1, 64'h0030_0020_0010_0000};

    rst_n     = 1'b0;
    in_v      = 1'b0;
    in_row    = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_reset", 64'(in_ready), 64'(1));

    // Table-driven tiles: plain, stalled column 1, one-grant-per-cycle.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      throttle = vecs[i].throttle;
      send_rows(vecs[i].base, vecs[i].gap);
      drain(vecs[i].base, vecs[i].stall_col, vecs[i].stall_len, vecs[i].lat);
      chk("tile_col0", col0_seen, vecs[i].col0);
      throttle = 1'b0;
    end

    // Back-to-back tiles: second tile enters right after tile_done.
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    begin
      int n0;
      n0 = ncols;
      fork
        begin
          send_rows(16'h000, 2);
          send_rows(16'h100, 2);
        end
      join_none
      wait_cols(n0 + 2 * M);
    end
    chk("b2b_col0", col0_seen, 64'h0130_0120_0110_0100);
    chk("b2b_accept_gap", 64'(first_acc_cyc - prev_done_cyc), 64'(1));

    // Reset while column 2 is being read, then a fresh tile.
    @(posedge clk);
    #1;
    begin
      int n0;
      n0 = ncols;
      send_rows(16'h000, 2);
      wait_cols(n0 + 2);
    end
    @(posedge clk);
    #1;
    chk("rd_before_reset", 64'(req_v), 64'(4'b1111));
    rst_n = 1'b0;
    #1;
    check_reset_vals("midreset");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_midreset", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    send_rows(16'h200, 2);
    drain(16'h200, -1, 0, 5);
    chk("fresh_col0", col0_seen, 64'h0230_0220_0210_0200);

    // Spurious responses while idle in WR must not touch the column buffer.
    @(posedge clk);
    #1;
    spur = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("spur_out_col", out_col, col_word(16'h200, 3));
      chk("spur_out_v", 64'(out_v), 64'(0));
    end
    spur = 1'b0;
    repeat (2) @(negedge clk);
    chk("spur_out_col_after", out_col, col_word(16'h200, 3));
    @(posedge clk);
    #1;
    send_rows(16'h300, 2);
    drain(16'h300, -1, 0, 5);
    chk("post_spur_col0", col0_seen, 64'h0330_0320_0310_0300);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
